// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and default widths for the cache arbiter
//
// Holds the arbiter FSM state enum, the grant encoding and the default
// cache-line / physical-address widths used across the memory hierarchy.
package cache_arb_pkg;

    localparam int CACHE_LINE_W = 256;
    localparam int CACHE_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/cache_arb_pick.sv
// rtl/cache_arb_pick.sv - combinational winner selection for the cache arbiter
//
// Ports:
//   i_req      in   I-cache is requesting the memory port
//   d_req      in   D-cache is requesting (read or write)
//   last_grant in   cache granted most recently
//   winner     out  cache to grant, GRANT_NONE when nobody requests
//
// Build option: CACHE_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// left undefined, the D-cache always wins a tie.
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output grant_t winner
);

    always_comb begin
        winner = GRANT_NONE;
        if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            winner = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
            winner = GRANT_D;
`endif
        end else if (i_req) begin
            winner = GRANT_I;
        end else if (d_req) begin
            winner = GRANT_D;
        end
    end

`ifndef CACHE_ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at history.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one physical-memory port between I-cache and D-cache
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_pmem_read/address           I-cache line-fill request
//   i_pmem_rdata/resp             fill data and completion pulse to I-cache
//   d_pmem_read/write/address/wdata  D-cache fill / writeback request
//   d_pmem_rdata/resp             fill data and completion pulse to D-cache
//   mem_read/write/address/wdata  request to memory
//   mem_rdata/resp                memory read data and completion
//
// Build option: CACHE_ARB_ROUND_ROBIN_EN (see cache_arb_pick).
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int LINE_W = CACHE_LINE_W,
    parameter int ADDR_W = CACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    grant_t            last_grant_q, last_grant_d;
    grant_t            winner;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              d_is_read;

    // Read and write together is treated as a writeback.
    assign d_is_read = d_pmem_read & ~d_pmem_write;

    cache_arb_pick u_pick (
        .i_req      (i_pmem_read),
        .d_req      (d_pmem_read | d_pmem_write),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = winner;
                if (winner != GRANT_NONE) begin
                    last_grant_d = winner;
                end
                case (winner)
                    GRANT_I: state_d = SERVE_I;
                    GRANT_D: state_d = SERVE_D;
                    default: state_d = IDLE;
                endcase
            end
            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_pmem_address;
                if (mem_resp) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            SERVE_D: begin
                mem_read    = d_is_read;
                mem_write   = d_pmem_write;
                mem_address = d_pmem_address;
                mem_wdata   = d_pmem_wdata;
                if (mem_resp) begin
                    if (d_is_read) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                // Requests are not sampled here: the cache drops its request
                // only in the cycle after it sees resp.
                i_pmem_resp = (grant_q == GRANT_I);
                d_pmem_resp = (grant_q == GRANT_D);
                grant_d     = GRANT_NONE;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_NONE;
            last_grant_q <= GRANT_I;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
        end
    end

    assign i_pmem_rdata = rdata_q;
    assign d_pmem_rdata = rdata_q;

endmodule
